// File: rtl/config_loader.sv
// config_loader: streams config words MSB-first into the prog scan chain.
// Define READBACK_EN to add a CRC-checked recirculating readback pass.
module config_loader #(
  parameter int CHAIN_LEN = 20,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              prog_rst,
  input  logic              start,
  input  logic [WORD_W-1:0] bs_data,
  input  logic              bs_valid,
  output logic              bs_ready,
  output logic              prog_en,
  output logic              chain_din,
  input  logic              chain_dout,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int WORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int REM   = CHAIN_LEN % WORD_W;
  localparam int LAST  = (REM == 0) ? WORD_W : REM;
  localparam int CW    = $clog2(WORD_W + 1);
  localparam int WW    = $clog2(WORDS + 1);
  localparam int BW    = $clog2(CHAIN_LEN + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
`ifdef READBACK_EN
    , S_RB
`endif
  } state_t;

  state_t            state;
  logic [WORD_W-1:0] buf_q;
  logic [CW-1:0]     buf_cnt;
  logic [WW-1:0]     words_left;
  logic [BW-1:0]     bits_left;

  logic in_load;
  logic shift;
  logic accept;
  logic last_bit;

  assign in_load  = (state == S_LOAD);
  assign shift    = in_load && (buf_cnt != '0);
  assign bs_ready = in_load && (buf_cnt <= CW'(1))
                 && (words_left != '0);
  assign accept   = bs_valid && bs_ready;
  assign last_bit = (bits_left == BW'(1));

`ifdef READBACK_EN
  logic        in_rb;
  logic [15:0] crc_tx;
  logic [15:0] crc_rx;
  logic        err_q;

  function automatic logic [15:0] crc_step(
    input logic [15:0] c,
    input logic        b
  );
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  assign in_rb     = (state == S_RB);
  assign prog_en   = shift || in_rb;
  // Readback recirculates the tail so the chain ends unchanged.
  assign chain_din = in_rb ? chain_dout
                           : (in_load & buf_q[WORD_W-1]);
  assign err       = err_q;

  always_ff @(posedge prog_clk or posedge prog_rst) begin
    if (prog_rst) begin
      crc_tx <= 16'hFFFF;
      crc_rx <= 16'hFFFF;
      err_q  <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        crc_tx <= 16'hFFFF;
        crc_rx <= 16'hFFFF;
        err_q  <= 1'b0;
      end
      if (shift)
        crc_tx <= crc_step(crc_tx, chain_din);
      if (in_rb) begin
        crc_rx <= crc_step(crc_rx, chain_dout);
        if (last_bit)
          err_q <= (crc_step(crc_rx, chain_dout) != crc_tx);
      end
    end
  end
`else
  logic unused_dout;
  assign unused_dout = chain_dout;
  assign prog_en     = shift;
  assign chain_din   = in_load & buf_q[WORD_W-1];
  assign err         = 1'b0;
`endif

  always_ff @(posedge prog_clk or posedge prog_rst) begin
    if (prog_rst) begin
      state      <= S_IDLE;
      buf_q      <= '0;
      buf_cnt    <= '0;
      words_left <= '0;
      bits_left  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_LOAD;
            buf_q      <= '0;
            buf_cnt    <= '0;
            words_left <= WW'(WORDS);
            bits_left  <= BW'(CHAIN_LEN);
            busy       <= 1'b1;
          end
        end
        S_LOAD: begin
          // A new word overrides the final shift of the old one.
          if (accept) begin
            buf_q      <= bs_data;
            buf_cnt    <= (words_left == WW'(1)) ? CW'(LAST)
                                                 : CW'(WORD_W);
            words_left <= words_left - 1'b1;
          end else if (shift) begin
            buf_q   <= buf_q << 1;
            buf_cnt <= buf_cnt - 1'b1;
          end
          if (shift) begin
            bits_left <= bits_left - 1'b1;
            if (last_bit) begin
`ifdef READBACK_EN
              state     <= S_RB;
              bits_left <= BW'(CHAIN_LEN);
`else
              state <= S_DONE;
              done  <= 1'b1;
`endif
            end
          end
        end
`ifdef READBACK_EN
        S_RB: begin
          bits_left <= bits_left - 1'b1;
          if (last_bit) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
`endif
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_config_loader.sv
// tb_config_loader: directed checks of config_loader against a chain model.
// Build with READBACK_EN defined to cover the readback pass.
module tb_config_loader;
  localparam int CL = 20;
`ifdef READBACK_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif
  localparam int EXP_EN = CL * (1 + RB);
  localparam logic [23:0] WDS = 24'hA53CF0;
  localparam logic [CL-1:0] GOOD = 20'hF3CA5;

  logic       prog_clk = 1'b0;
  logic       prog_rst = 1'b1;
  logic       start    = 1'b0;
  logic [7:0] bs_data  = 8'h00;
  logic       bs_valid = 1'b0;
  logic       bs_ready;
  logic       prog_en;
  logic       chain_din;
  logic       chain_dout;
  logic       busy;
  logic       done;
  logic       err;

  always #5 prog_clk = ~prog_clk;

  config_loader #(.CHAIN_LEN(CL), .WORD_W(8)) dut (
    .prog_clk  (prog_clk),
    .prog_rst  (prog_rst),
    .start     (start),
    .bs_data   (bs_data),
    .bs_valid  (bs_valid),
    .bs_ready  (bs_ready),
    .prog_en   (prog_en),
    .chain_din (chain_din),
    .chain_dout(chain_dout),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  // Chain model: head at MSB, tail at bit 0.
  logic [CL-1:0] chain = '0;
  int   en_cnt   = 0;
  int   runs     = 0;
  logic en_q     = 1'b0;
  logic mclr     = 1'b0;
  logic flip_arm = 1'b0;

  assign chain_dout = chain[0];

  always @(posedge prog_clk) begin
    if (mclr) begin
      en_cnt <= 0;
      runs   <= 0;
      en_q   <= 1'b0;
    end else begin
      en_q <= prog_en;
      if (prog_en) begin
        en_cnt <= en_cnt + 1;
        if (!en_q) runs <= runs + 1;
        chain <= {chain_din, chain[CL-1:1]}
               ^ ((flip_arm && en_cnt == CL - 1) ? 20'h00010 : 20'h0);
      end
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] wsel(input logic [23:0] w, input int k);
    case (k)
      0: return w[23:16];
      1: return w[15:8];
      2: return w[7:0];
      default: return 8'h00;
    endcase
  endfunction

  task automatic run_load(input logic [23:0] w, input int gap,
                          input int restart, input int abort_at,
                          output int cyc);
    int k;
    int gapc;
    int t;
    bit acc;
    bit rdy;
    bit ab;
    k = 0; gapc = 0; ab = 0;
    @(posedge prog_clk); #1;
    mclr = 1'b1;
    @(posedge prog_clk); #1;
    mclr = 1'b0;
    bs_data = wsel(w, 0);
    bs_valid = 1'b1;
    start = 1'b1;
    @(posedge prog_clk); #1;
    start = 1'b0;
    t = 1;
    chk("busy_s1", busy, 1);
    chk("ready_s1", bs_ready, 1);
    chk("err_s1", err, 0);
    while (!done && !ab && t < 200) begin
      @(negedge prog_clk);
      acc = bs_valid && bs_ready;
      rdy = bs_ready;
      @(posedge prog_clk); #1;
      t++;
      if (acc) begin
        k++;
        gapc = gap;
      end else if (gapc > 0 && rdy) begin
        gapc--;
      end
      bs_valid = (k < 3) && (gapc == 0);
      bs_data = wsel(w, k);
      start = (t == restart);
      if (abort_at > 0 && en_cnt == abort_at) ab = 1;
    end
    start = 1'b0;
    bs_valid = 1'b0;
    cyc = t;
  endtask

  typedef struct {
    string         name;
    int            gap;
    int            restart;
    logic [CL-1:0] exp_chain;
    int            exp_cyc;
    int            exp_runs;
  } vec_t;

  vec_t vecs[3];

  initial begin
    int cyc;
    vecs[0] = '{"cont",    0, 0,  GOOD, 22 + 20 * RB, 1};
    vecs[1] = '{"gap5",    5, 0,  GOOD, 32 + 20 * RB, 3};
    vecs[2] = '{"restart", 0, 10, GOOD, 22 + 20 * RB, 1};

    repeat (3) @(posedge prog_clk);
    #1;
    chk("reset_outs", {bs_ready, prog_en, chain_din, busy, done, err}, 0);
    prog_rst = 1'b0;

    for (int i = 0; i < 3; i++) begin
      run_load(WDS, vecs[i].gap, vecs[i].restart, 0, cyc);
      chk({vecs[i].name, "_cyc"}, cyc, vecs[i].exp_cyc);
      chk({vecs[i].name, "_busy_done"}, busy, 1);
      chk({vecs[i].name, "_err"}, err, 0);
      @(posedge prog_clk); #1;
      chk({vecs[i].name, "_post"}, {done, busy}, 0);
      chk({vecs[i].name, "_en"}, en_cnt, EXP_EN);
      chk({vecs[i].name, "_runs"}, runs, vecs[i].exp_runs);
      chk({vecs[i].name, "_chain"}, chain, vecs[i].exp_chain);
    end

    // Reset after 7 shifts, then a full reload.
    run_load(WDS, 0, 0, 7, cyc);
    chk("abort_shifts", en_cnt, 7);
    prog_rst = 1'b1;
    #1;
    chk("abort_outs", {bs_ready, prog_en, chain_din, busy, done, err}, 0);
    @(posedge prog_clk); #1;
    prog_rst = 1'b0;
    run_load(WDS, 0, 0, 0, cyc);
    chk("reload_cyc", cyc, 22 + 20 * RB);
    @(posedge prog_clk); #1;
    chk("reload_chain", chain, GOOD);

`ifdef READBACK_EN
    flip_arm = 1'b1;
    run_load(WDS, 0, 0, 0, cyc);
    flip_arm = 1'b0;
    chk("flip_cyc", cyc, 42);
    chk("flip_err", err, 1);
    repeat (4) @(posedge prog_clk);
    #1;
    chk("flip_err_hold", err, 1);
    chk("flip_chain", chain, GOOD ^ 20'h00010);
    run_load(WDS, 0, 0, 0, cyc);
    chk("clean_err", err, 0);
    @(posedge prog_clk); #1;
    chk("clean_chain", chain, GOOD);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
